// File: rtl/fft_unload_if.sv
// Handshake/bus bundle between the FFT result unloader, the four bank RAMs and
// the downstream sample consumer.
interface fft_unload_if #(
    parameter int DATA_W = 16
);
    logic              iSTART;
    logic [8:0]        oADDR_RD;
    logic [1:0]        oBANK_SEL;
    logic              oRD_EN;
    logic [DATA_W-1:0] iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
    logic [DATA_W-1:0] iDATA_IM_0, iDATA_IM_1, iDATA_IM_2, iDATA_IM_3;
    logic [DATA_W-1:0] oDATA_RE, oDATA_IM;
    logic              oVALID;
    logic              iREADY;
    logic [10:0]       oINDEX;
    logic              oLAST;
    logic              oBUSY;
    logic              oDONE;

    modport master (
        input  iSTART, iREADY,
        input  iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3,
        input  iDATA_IM_0, iDATA_IM_1, iDATA_IM_2, iDATA_IM_3,
        output oADDR_RD, oBANK_SEL, oRD_EN, oDATA_RE, oDATA_IM,
        output oVALID, oINDEX, oLAST, oBUSY, oDONE
    );

    modport slave (
        output iSTART, iREADY,
        output iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3,
        output iDATA_IM_0, iDATA_IM_1, iDATA_IM_2, iDATA_IM_3,
        input  oADDR_RD, oBANK_SEL, oRD_EN, oDATA_RE, oDATA_IM,
        input  oVALID, oINDEX, oLAST, oBUSY, oDONE
    );
endinterface

// File: rtl/fft_unload.sv
// Unloads 2048 FFT results from four bank RAMs in natural bin order through a
// small credit-limited FIFO. Define FFT_UNLOAD_DIGIT_REV_EN for radix-4 digit-reversed storage.
module fft_unload #(
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          iCLK,
    input  logic          iRESET,
    fft_unload_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [10:0] map_idx(input logic [10:0] n);
`ifdef FFT_UNLOAD_DIGIT_REV_EN
        return {n[1:0], n[3:2], n[5:4], n[7:6], n[9:8], n[10]};
`else
        return n;
`endif
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                  state;
    logic [10:0]             rd_n, out_n, s;
    logic [RD_LAT:1]         vld_pipe;
    logic [RD_LAT:1][1:0]    bank_pipe;
    logic [DATA_W-1:0]       mem_re [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_im [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt, cnt_nxt;
    logic [SUM_W-1:0]        inflight;
    logic                    pend_keep, rd_en, wr, pop, drained;
    logic [DATA_W-1:0]       wr_re, wr_im;

    assign s = map_idx(rd_n);

    // A read is credited against the FIFO from issue until its pop; a pop only
    // returns its credit on the following cycle since fifo_cnt is registered.
    always_comb begin
        inflight  = '0;
        pend_keep = 1'b0;
        for (int k = 1; k <= RD_LAT; k++) begin
            inflight = inflight + SUM_W'(vld_pipe[k]);
            if (k < RD_LAT) pend_keep = pend_keep | vld_pipe[k];
        end
    end

    assign rd_en   = (state == RUN) && ((SUM_W'(fifo_cnt) + inflight) < SUM_W'(FIFO_DEPTH));
    assign wr      = vld_pipe[RD_LAT];
    assign pop     = (fifo_cnt != '0) && bus.iREADY;
    assign cnt_nxt = fifo_cnt + CNT_W'(wr) - CNT_W'(pop);
    assign drained = (cnt_nxt == '0) && !pend_keep;

    always_comb begin
        wr_re = bus.iDATA_RE_0;
        wr_im = bus.iDATA_IM_0;
        case (bank_pipe[RD_LAT])
            2'd1: begin wr_re = bus.iDATA_RE_1; wr_im = bus.iDATA_IM_1; end
            2'd2: begin wr_re = bus.iDATA_RE_2; wr_im = bus.iDATA_IM_2; end
            2'd3: begin wr_re = bus.iDATA_RE_3; wr_im = bus.iDATA_IM_3; end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state     <= IDLE;
            rd_n      <= '0;
            out_n     <= '0;
            vld_pipe  <= '0;
            bank_pipe <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            vld_pipe[1]  <= rd_en;
            bank_pipe[1] <= s[10:9];
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                bank_pipe[k] <= bank_pipe[k-1];
            end
            if (wr) begin
                mem_re[wr_ptr] <= wr_re;
                mem_im[wr_ptr] <= wr_im;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                if (out_n != 11'd2047) out_n <= out_n + 11'd1;
            end
            fifo_cnt <= cnt_nxt;
            case (state)
                IDLE: if (bus.iSTART) begin
                    state <= RUN;
                    rd_n  <= '0;
                    out_n <= '0;
                end
                RUN: if (rd_en) begin
                    if (rd_n == 11'd2047) state <= DRAIN;
                    else                  rd_n  <= rd_n + 11'd1;
                end
                DRAIN: if (drained) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oRD_EN    = rd_en;
    assign bus.oADDR_RD  = s[8:0];
    assign bus.oBANK_SEL = s[10:9];
    assign bus.oVALID    = (fifo_cnt != '0);
    assign bus.oDATA_RE  = mem_re[rd_ptr];
    assign bus.oDATA_IM  = mem_im[rd_ptr];
    assign bus.oINDEX    = out_n;
    assign bus.oLAST     = (fifo_cnt != '0) && (out_n == 11'd2047);
    assign bus.oBUSY     = (state == RUN) || (state == DRAIN);
    assign bus.oDONE     = (state == DONE);
endmodule

// File: tb/tb_fft_unload.sv
// Self-checking bench for fft_unload: bank RAM model, cycle-level reference
// monitor, latency/mapping tables and backpressure/restart/abort sequences.
module tb_fft_unload;
    localparam int DATA_W     = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic iCLK = 1'b0;
    logic iRESET;
    always #5 iCLK = ~iCLK;

    fft_unload_if #(.DATA_W(DATA_W)) bus();

    fft_unload #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    // Bank k holds k*512+addr (real) and its complement (imag).
    logic [8:0] a_pipe [RD_LAT];
    always @(posedge iCLK) begin
        a_pipe[0] <= bus.oADDR_RD;
        for (int k = 1; k < RD_LAT; k++) a_pipe[k] <= a_pipe[k-1];
    end
    always_comb begin
        bus.iDATA_RE_0 = DATA_W'({2'd0, a_pipe[RD_LAT-1]});
        bus.iDATA_RE_1 = DATA_W'({2'd1, a_pipe[RD_LAT-1]});
        bus.iDATA_RE_2 = DATA_W'({2'd2, a_pipe[RD_LAT-1]});
        bus.iDATA_RE_3 = DATA_W'({2'd3, a_pipe[RD_LAT-1]});
        bus.iDATA_IM_0 = ~bus.iDATA_RE_0;
        bus.iDATA_IM_1 = ~bus.iDATA_RE_1;
        bus.iDATA_IM_2 = ~bus.iDATA_RE_2;
        bus.iDATA_IM_3 = ~bus.iDATA_RE_3;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Storage index for bin n, by digit arithmetic.
    function automatic int map_tb(input int n);
`ifdef FFT_UNLOAD_DIGIT_REV_EN
        int r = 0, m = n % 1024;
        for (int d = 0; d < 5; d++) begin
            r = r * 4 + m % 4;
            m = m / 4;
        end
        return r * 2 + n / 1024;
`else
        return n;
`endif
    endfunction

    bit                active = 0, done_due = 0, stall_prev = 0, pre_last;
    int                exp_n, rd_n, issued, accepted, beats, first_cyc, last_cyc;
    int                done_cyc, done_cnt, cycn = 0, pre_idx;
    logic [DATA_W-1:0] pre_re, pre_im, exp_re;
    int                obs_bank [2048];
    int                obs_addr [2048];

    task automatic monitor_step();
        bit act0;
        cycn++;
        if (iRESET) begin
            active = 0; done_due = 0; stall_prev = 0;
            exp_n = 0; rd_n = 0; issued = 0; accepted = 0;
            return;
        end
        act0 = active;
        chk("done", bus.oDONE, done_due);
        chk("busy", bus.oBUSY, active && !done_due);
        if (!act0) begin
            chk("rd_idle", bus.oRD_EN, 0);
            chk("vld_idle", bus.oVALID, 0);
        end
        if (done_due) begin
            done_cnt++; done_cyc = cycn; done_due = 0; active = 0;
        end
        if (bus.oRD_EN) begin
            chk("occupancy", (issued + 1 - accepted) <= FIFO_DEPTH, 1);
            chk("rd_range", rd_n < 2048, 1);
            if (rd_n < 2048) begin
                chk("rd_map", {bus.oBANK_SEL, bus.oADDR_RD}, map_tb(rd_n));
                obs_bank[rd_n] = int'(bus.oBANK_SEL);
                obs_addr[rd_n] = int'(bus.oADDR_RD);
            end
            rd_n++; issued++;
        end
        if (stall_prev) begin
            chk("stall_vld", bus.oVALID, 1);
            chk("stall_re", bus.oDATA_RE, pre_re);
            chk("stall_im", bus.oDATA_IM, pre_im);
            chk("stall_idx", bus.oINDEX, pre_idx);
            chk("stall_last", bus.oLAST, pre_last);
        end
        if (bus.oVALID) begin
            exp_re = DATA_W'(map_tb(exp_n));
            chk("idx", bus.oINDEX, exp_n);
            chk("re", bus.oDATA_RE, exp_re);
            chk("im", bus.oDATA_IM, DATA_W'(~exp_re));
            chk("last", bus.oLAST, exp_n == 2047);
            if (bus.iREADY) begin
                if (beats == 0) first_cyc = cycn;
                last_cyc = cycn;
                beats++; accepted++;
                if (exp_n == 2047) done_due = 1;
                exp_n++;
            end
        end
        stall_prev = bus.oVALID && !bus.iREADY;
        pre_re = bus.oDATA_RE; pre_im = bus.oDATA_IM;
        pre_idx = int'(bus.oINDEX); pre_last = bus.oLAST;
        if (bus.iSTART && !act0) begin
            active = 1; exp_n = 0; rd_n = 0; issued = 0; accepted = 0;
            beats = 0; done_cnt = 0; first_cyc = -1;
        end
    endtask

    // Advance one cycle: monitor on the falling edge, return 1 time unit after the next rising edge.
    task automatic cyc();
        @(negedge iCLK);
        monitor_step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vld"},  bus.oVALID, 0);
        chk({tag, "_rden"}, bus.oRD_EN, 0);
        chk({tag, "_last"}, bus.oLAST, 0);
        chk({tag, "_busy"}, bus.oBUSY, 0);
        chk({tag, "_done"}, bus.oDONE, 0);
        chk({tag, "_addr"}, bus.oADDR_RD, 0);
        chk({tag, "_bank"}, bus.oBANK_SEL, 0);
        chk({tag, "_idx"},  bus.oINDEX, 0);
        chk({tag, "_re"},   bus.oDATA_RE, 0);
        chk({tag, "_im"},   bus.oDATA_IM, 0);
    endtask

    task automatic start_run();
        bus.iSTART = 1'b1;
        cyc();
        bus.iSTART = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        int b = 0;
        while (!(bus.oVALID && int'(bus.oINDEX) == target) && b < 4000) begin
            cyc(); b++;
        end
        chk("wait_idx_timeout", b < 4000, 1);
    endtask

    task automatic wait_done(input bit rnd);
        int b = 0;
        while (!bus.oDONE && b < 12000) begin
            if (rnd) bus.iREADY = 1'($urandom % 2);
            cyc(); b++;
        end
        chk("done_timeout", b < 12000, 1);
        bus.iREADY = 1'b1;
        repeat (3) cyc();
        chk("beats", beats, 2048);
        chk("done_cnt", done_cnt, 1);
    endtask

    typedef struct { int cyc; bit rd; bit vld; bit busy; int idx; } lat_t;
    typedef struct { int n; int bank; int addr; } map_t;
    lat_t lat_tab [6];
    map_t map_tab [5];

    initial begin
        lat_tab[0] = '{0, 0, 0, 0, 0};
        lat_tab[1] = '{1, 1, 0, 1, 0};
        lat_tab[2] = '{2, 1, 0, 1, 0};
        lat_tab[3] = '{3, 1, 0, 1, 0};
        lat_tab[4] = '{4, 1, 1, 1, 0};
        lat_tab[5] = '{5, 1, 1, 1, 1};
`ifdef FFT_UNLOAD_DIGIT_REV_EN
        map_tab[0] = '{0, 0, 0};     map_tab[1] = '{1, 1, 0};
        map_tab[2] = '{4, 0, 128};   map_tab[3] = '{1024, 0, 1};
        map_tab[4] = '{2047, 3, 511};
`else
        map_tab[0] = '{0, 0, 0};     map_tab[1] = '{1, 0, 1};
        map_tab[2] = '{4, 0, 4};     map_tab[3] = '{1024, 2, 0};
        map_tab[4] = '{2047, 3, 511};
`endif
        iRESET = 1'b1;
        bus.iSTART = 1'b0;
        bus.iREADY = 1'b0;
        repeat (3) cyc();
        check_zero("reset");
        iRESET = 1'b0;
        cyc();

        // Full-rate run: latency table, then consecutive beats and mapping spot checks.
        bus.iREADY = 1'b1;
        bus.iSTART = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("lat%0d_rden", c), bus.oRD_EN, lat_tab[c].rd);
            chk($sformatf("lat%0d_vld", c), bus.oVALID, lat_tab[c].vld);
            chk($sformatf("lat%0d_busy", c), bus.oBUSY, lat_tab[c].busy);
            if (lat_tab[c].vld) chk($sformatf("lat%0d_idx", c), bus.oINDEX, lat_tab[c].idx);
            cyc();
            bus.iSTART = 1'b0;
        end
        wait_done(0);
        chk("consecutive", last_cyc - first_cyc, 2047);
        chk("done_after_last", done_cyc, last_cyc + 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("map%0d_bank", map_tab[i].n), obs_bank[map_tab[i].n], map_tab[i].bank);
            chk($sformatf("map%0d_addr", map_tab[i].n), obs_addr[map_tab[i].n], map_tab[i].addr);
        end

        // Backpressure at n=10 for 20 cycles.
        start_run();
        wait_idx(10);
        bus.iREADY = 1'b0;
        repeat (20) cyc();
        chk("bp_idx_hold", bus.oINDEX, 10);
        chk("bp_vld_hold", bus.oVALID, 1);
        chk("bp_rd_stopped", bus.oRD_EN, 0);
        bus.iREADY = 1'b1;
        wait_done(0);

        // Second iSTART mid-run is ignored.
        start_run();
        wait_idx(500);
        bus.iSTART = 1'b1;
        cyc();
        bus.iSTART = 1'b0;
        wait_done(0);

        // Reset abort during backpressure, with iSTART in the reset cycle.
        start_run();
        wait_idx(1000);
        bus.iREADY = 1'b0;
        repeat (3) cyc();
        iRESET = 1'b1;
        bus.iSTART = 1'b1;
        cyc();
        iRESET = 1'b0;
        bus.iSTART = 1'b0;
        check_zero("abort");
        bus.iREADY = 1'b1;
        repeat (RD_LAT + 3) cyc();
        chk("abort_no_stale", bus.oVALID, 0);
        chk("abort_no_done", done_cnt, 0);
        start_run();
        wait_done(0);

        // Random 50% backpressure.
        start_run();
        wait_done(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
